// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between the controller and the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  // Controller side: issues operands and start, observes status and result.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor
// cell and a borrow flop, WIDTH cycles per operation.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave sub_if
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             fs_d;
  logic             fs_borrow;
  logic [WIDTH-1:0] diff_shifted;
  logic             unused_diff_lsb;

  // Single full-subtractor cell on the current LSBs plus the stored borrow.
  always_comb begin
    fs_d         = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    fs_borrow    = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    diff_shifted = {fs_d, diff_sh_q[WIDTH-1:1]};
  end

  // The oldest result bit falls off the bottom of the shift register.
  assign unused_diff_lsb = diff_sh_q[0];

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    bout_d    = bout_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sub_if.start) begin
          a_sh_d   = sub_if.a;
          b_sh_d   = sub_if.b;
          borrow_d = sub_if.bin;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        borrow_d  = fs_borrow;
        diff_sh_d = diff_shifted;
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          diff_d  = diff_shifted;
          bout_d  = fs_borrow;
          done_d  = 1'b1;
          // Park the counter rather than let it wrap for power-of-two widths.
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      bout_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      bout_q    <= bout_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sub_if.busy = (state_q != StIdle);
  assign sub_if.done = done_q;
  assign sub_if.diff = diff_q;
  assign sub_if.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4 and WIDTH=8 instances).
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .sub_if (bus4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .sub_if (bus8)
  );

  typedef struct {
    int d;
    int b;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  exp_t sb4[$];
  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one request on the WIDTH=4 unit and queue its expected result.
  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        input int ed, input int eb);
    exp_t e;
    @(negedge clk);
    bus4.a     = a;
    bus4.b     = b;
    bus4.bin   = bin;
    bus4.start = 1'b1;
    e.d = ed;
    e.b = eb;
    sb4.push_back(e);
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    // Scramble operands: the captured values must be the ones used.
    bus4.a     = ~a;
    bus4.b     = ~b;
    bus4.bin   = ~bin;
    chk("busy after accept", {31'd0, bus4.busy}, 32'd1);
  endtask

  // Wait (bounded) for done on the WIDTH=4 unit; check latency, result, busy length.
  task automatic wait_done4(input string name);
    int   lat    = 0;
    int   busy_n = 1;
    exp_t e;
    while (bus4.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus4.busy === 1'b1) busy_n++;
    end
    chk({name, " latency"}, lat, 32'd4);
    if (bus4.done === 1'b1) begin
      if (sb4.size() > 0) begin
        e = sb4.pop_front();
      end else begin
        e.d = -1;
        e.b = -1;
      end
      chk({name, " diff"}, {28'd0, bus4.diff}, e.d);
      chk({name, " bout"}, {31'd0, bus4.bout}, e.b);
    end
    @(posedge clk);
    #1;
    if (bus4.busy === 1'b1) busy_n++;
    chk({name, " done pulse width"}, {31'd0, bus4.done}, 32'd0);
    chk({name, " busy low after done"}, {31'd0, bus4.busy}, 32'd0);
    chk({name, " busy cycles"}, busy_n, 32'd5);
    chk({name, " diff hold"}, {28'd0, bus4.diff}, e.d);
  endtask

  initial begin : timeout
    #400000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    exp_t e;
    int   lat;

    vecs[0] = '{a: 4'd9,  b: 4'd5,  bin: 1'b0, d: 4'd4,  bo: 1'b0};
    vecs[1] = '{a: 4'd5,  b: 4'd9,  bin: 1'b0, d: 4'd12, bo: 1'b1};
    vecs[2] = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'd15, bo: 1'b1};
    vecs[3] = '{a: 4'd15, b: 4'd15, bin: 1'b0, d: 4'd0,  bo: 1'b0};
    vecs[4] = '{a: 4'd0,  b: 4'd15, bin: 1'b1, d: 4'd0,  bo: 1'b1};
    vecs[5] = '{a: 4'd7,  b: 4'd2,  bin: 1'b0, d: 4'd5,  bo: 1'b0};

    rst        = 1'b1;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus4.bin   = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.bin   = 1'b0;
    #12;
    chk("reset busy", {31'd0, bus4.busy}, 32'd0);
    chk("reset done", {31'd0, bus4.done}, 32'd0);
    chk("reset diff", {28'd0, bus4.diff}, 32'd0);
    chk("reset bout", {31'd0, bus4.bout}, 32'd0);
    chk("reset diff w8", {24'd0, bus8.diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      start4(vecs[i].a, vecs[i].b, vecs[i].bin, int'(vecs[i].d), int'(vecs[i].bo));
      wait_done4($sformatf("vec%0d", i));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("diff held while idle", {28'd0, bus4.diff}, 32'd5);

    // Start held high through SHIFT/DONE with changing operands.
    @(negedge clk);
    bus4.a = 4'd9; bus4.b = 4'd5; bus4.bin = 1'b0; bus4.start = 1'b1;
    e.d = 4; e.b = 0;
    sb4.push_back(e);
    @(posedge clk);
    #1;
    bus4.a = 4'd3; bus4.b = 4'd7;
    wait_done4("held start first");
    e.d = 12; e.b = 1;
    sb4.push_back(e);
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    chk("held start re-accept busy", {31'd0, bus4.busy}, 32'd1);
    wait_done4("held start second");

    // Asynchronous reset mid-operation.
    start4(4'd9, 4'd5, 1'b0, 4, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, bus4.busy}, 32'd0);
    chk("async rst done", {31'd0, bus4.done}, 32'd0);
    chk("async rst diff", {28'd0, bus4.diff}, 32'd0);
    chk("async rst bout", {31'd0, bus4.bout}, 32'd0);
    sb4.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("no done after abandon", {31'd0, bus4.done}, 32'd0);
    end
    start4(4'd7, 4'd2, 1'b0, 5, 0);
    wait_done4("after reset");

    // Exhaustive back-to-back against the arithmetic model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          start4(4'(a), 4'(b), 1'(bi), (a - b - bi) & 15, (a < b + bi) ? 1 : 0);
          wait_done4($sformatf("exh a=%0d b=%0d bin=%0d", a, b, bi));
        end
      end
    end

    // WIDTH=8 regression: full borrow ripple.
    @(negedge clk);
    bus8.a = 8'h00; bus8.b = 8'h01; bus8.bin = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'hAA;
    bus8.b     = 8'h55;
    lat        = 0;
    while (bus8.done !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w8 latency", lat, 32'd8);
    chk("w8 diff", {24'd0, bus8.diff}, 32'hFF);
    chk("w8 bout", {31'd0, bus8.bout}, 32'd1);
    @(posedge clk);
    #1;
    chk("w8 done pulse width", {31'd0, bus8.done}, 32'd0);
    chk("w8 busy low", {31'd0, bus8.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Built around the team's single-bit full-subtractor cell plus a borrow flip-flop.
- Sits directly upstream of wide-result consumers. Trades WIDTH cycles of latency for one FS cell of area.
- Start/busy/done handshake to the controller.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; diff/bout valid.
- diff  output  WIDTH  difference, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 iff a < b + bin as unsigned values.

Behaviour:
- Reset (async, any time): state=IDLE; a_sh, b_sh, diff_sh, borrow, cnt all 0; busy=0, done=0, diff=0, bout=0. An in-flight operation is abandoned with no done pulse.
- Reset deassertion: the first edge after rst falls may accept start.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0.
  - On an edge with start=1: a_sh<=a, b_sh<=b, borrow<=bin, cnt<=0, state<=SHIFT.
  - Otherwise hold.
- SHIFT, each edge:
  - a0=a_sh[0], b0=b_sh[0].
  - d = a0 ^ b0 ^ borrow.
  - borrow <= (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - diff_sh <= {d, diff_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1 with zero fill.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: load diff <= final shifted value, bout <= final borrow, done<=1, state<=DONE.
- DONE:
  - done=1 for exactly one cycle; busy=1.
  - Next edge: done<=0, state<=IDLE.
- Latency:
  - done rises at the WIDTH-th rising edge after the edge that accepted start.
  - The next start can be accepted WIDTH+2 edges after the previous accept, counting the accept edge itself (the edge in IDLE after DONE).
- diff and bout:
  - Registered.
  - Change only on the edge that raises done, or on reset.
  - Hold between operations.
- start while busy (SHIFT or DONE): ignored. It is not queued, and operands are not re-captured.
- a, b, bin may change freely after the accepting edge with no effect on the result.
- cnt width: $clog2(WIDTH), no wrap within one operation.
- Boundary values: a=b with bin=0 gives diff=0, bout=0. a=0, b=0, bin=1 gives all-ones, bout=1. Maximum-borrow cases must ripple through all WIDTH bits.

Test Plan:
- WIDTH=4, a=9, b=5, bin=0, pulse start -> done high at the 4th edge after accept, diff=4, bout=0, busy low one cycle later.
- a=5, b=9, bin=0 -> diff=12 (4'b1100), bout=1. Then a=0, b=0, bin=1 -> diff=15, bout=1. Then a=15, b=15, bin=0 -> diff=0, bout=0.
- Start accepted with a=9, b=5; hold start=1 and change a=3, b=7 during SHIFT/DONE -> result still diff=4, bout=0, no second done. Second accept happens only on the IDLE edge, then diff=12, bout=1.
- Assert rst for one cycle after the 2nd SHIFT edge -> busy=0, done=0, diff=0, bout=0 immediately (async). No done pulse. A fresh start of 7-2-0 afterwards -> diff=5, bout=0.
- Exhaustive: all 512 (a, b, bin) combinations back-to-back, WIDTH=4 -> each done pulse matches the model ((a-b-bin) mod 16, a < b+bin). busy is high for exactly 5 cycles per operation.
- WIDTH=8 regression: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, done at the 8th edge after accept.
